// File: rtl/led_pkg.sv
// Shared constants and read-FSM encoding for the LED frame buffer.
package led_pkg;
  localparam int NUM_LEDS     = 72;
  localparam int NUM_CHANNELS = 3 * NUM_LEDS;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_READY = 2'd3
  } rd_state_t;
endpackage

// File: rtl/fb_dp_ram.sv
// Two-bank byte store: one write port, one registered read port.
// Address MSB selects the bank; no reset so it maps onto block RAM.
module fb_dp_ram #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH:0]   wr_addr,
  input  logic [7:0]            wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH:0]   rd_addr,
  output logic [7:0]            rd_data
);
  logic [7:0] mem [0:(2 * (2 ** ADDR_WIDTH)) - 1];

  // Write port
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read port; output holds while rd_en is low
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/led_frame_buffer.sv
// Double-buffered LED frame store. The SPI side fills the back bank while
// the strip driver reads the front bank through a 4-phase handshake; a
// requested swap is deferred until the driver starts a new frame (ch 0).
module led_frame_buffer import led_pkg::*; #(
  parameter int NUM_CHANNELS = led_pkg::NUM_CHANNELS,
  parameter int ADDR_WIDTH   = 8,
  parameter int READ_DELAY   = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [7:0]              wr_data,
  input  logic                    swap_req,
  input  logic                    rd_req,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic                    rd_rdy,
  output logic [7:0]              rd_data,
  output logic                    front_bank,
  output logic                    swap_pending
);
  localparam logic [ADDR_WIDTH:0] CH_LIMIT = (ADDR_WIDTH + 1)'(NUM_CHANNELS);
  localparam int DW = (READ_DELAY > 1) ? $clog2(READ_DELAY) : 1;
  localparam logic [DW-1:0] DLY_LAST = DW'((READ_DELAY > 0) ? READ_DELAY - 1 : 0);

  rd_state_t       state;
  logic [DW-1:0]   dly_cnt;
  logic            rd_oob;
  logic [7:0]      ram_q;
  logic            accept;
  logic            apply_swap;
  logic            read_bank;
  logic            wr_ok;

  assign accept     = (state == ST_IDLE) && rd_req;
  // Swap only at a frame boundary, i.e. when the driver asks for channel 0
  assign apply_swap = accept && swap_pending && (rd_addr == '0);
  // The read issued in the swap cycle already targets the new front bank
  assign read_bank  = front_bank ^ apply_swap;
  assign wr_ok      = wr_en && ({1'b0, wr_addr} < CH_LIMIT);

  fb_dp_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk     (clk),
    .wr_en   (wr_ok),
    .wr_addr ({~front_bank, wr_addr}),
    .wr_data (wr_data),
    .rd_en   (accept),
    .rd_addr ({read_bank, rd_addr}),
    .rd_data (ram_q)
  );

  // Bank select and deferred-swap bookkeeping; a new request in the apply
  // cycle re-arms pending
  always_ff @(posedge clk) begin
    if (rst) begin
      front_bank   <= 1'b0;
      swap_pending <= 1'b0;
    end else begin
      if (apply_swap) front_bank <= ~front_bank;
      swap_pending <= (swap_pending & ~apply_swap) | swap_req;
    end
  end

  // Read handshake FSM; rd_data only changes on the capture into READY
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      rd_rdy  <= 1'b0;
      rd_data <= 8'h00;
      dly_cnt <= '0;
      rd_oob  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rd_req) begin
            state  <= ST_FETCH;
            rd_oob <= ~({1'b0, rd_addr} < CH_LIMIT);
          end
        end
        ST_FETCH: begin
          if (!rd_req) begin
            state <= ST_IDLE;
          end else if (READ_DELAY > 0) begin
            state   <= ST_WAIT;
            dly_cnt <= '0;
          end else begin
            state   <= ST_READY;
            rd_rdy  <= 1'b1;
            rd_data <= rd_oob ? 8'h00 : ram_q;
          end
        end
        ST_WAIT: begin
          if (!rd_req) begin
            state   <= ST_IDLE;
            dly_cnt <= '0;
          end else if (dly_cnt == DLY_LAST) begin
            state   <= ST_READY;
            rd_rdy  <= 1'b1;
            rd_data <= rd_oob ? 8'h00 : ram_q;
            dly_cnt <= '0;
          end else begin
            dly_cnt <= dly_cnt + DW'(1);
          end
        end
        ST_READY: begin
          if (!rd_req) begin
            state  <= ST_IDLE;
            rd_rdy <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_led_frame_buffer.sv
// Directed bench: instance 0 (no read delay) runs a vector table, instance 1
// (READ_DELAY=10) covers long latency, abort and reset-in-handshake.
module tb_led_frame_buffer;
  logic       clk = 1'b0;
  logic       rst      [2];
  logic       wr_en    [2];
  logic [7:0] wr_addr  [2];
  logic [7:0] wr_data  [2];
  logic       swap_req [2];
  logic       rd_req   [2];
  logic [7:0] rd_addr  [2];
  logic       rd_rdy   [2];
  logic [7:0] rd_data  [2];
  logic       front_bank   [2];
  logic       swap_pending [2];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  led_frame_buffer #(.NUM_CHANNELS(216), .ADDR_WIDTH(8), .READ_DELAY(0)) dut0 (
    .clk(clk), .rst(rst[0]), .wr_en(wr_en[0]), .wr_addr(wr_addr[0]),
    .wr_data(wr_data[0]), .swap_req(swap_req[0]), .rd_req(rd_req[0]),
    .rd_addr(rd_addr[0]), .rd_rdy(rd_rdy[0]), .rd_data(rd_data[0]),
    .front_bank(front_bank[0]), .swap_pending(swap_pending[0]));

  led_frame_buffer #(.NUM_CHANNELS(216), .ADDR_WIDTH(8), .READ_DELAY(10)) dut1 (
    .clk(clk), .rst(rst[1]), .wr_en(wr_en[1]), .wr_addr(wr_addr[1]),
    .wr_data(wr_data[1]), .swap_req(swap_req[1]), .rd_req(rd_req[1]),
    .rd_addr(rd_addr[1]), .rd_rdy(rd_rdy[1]), .rd_data(rd_data[1]),
    .front_bank(front_bank[1]), .swap_pending(swap_pending[1]));

  typedef struct {
    logic       w;   // write strobe
    logic [7:0] wa;
    logic [7:0] wd;
    logic       s;   // swap_req
    logic       r;   // perform a read (write/swap share its first cycle)
    logic [7:0] ra;
    logic [7:0] ed;  // expected read byte
    logic       ef;  // expected front_bank afterwards
    logic       ep;  // expected swap_pending afterwards
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic pulse(input int i, input logic w, input logic [7:0] a,
                       input logic [7:0] d, input logic s);
    cyc();
    wr_en[i] = w; wr_addr[i] = a; wr_data[i] = d; swap_req[i] = s;
    cyc();
    wr_en[i] = 1'b0; swap_req[i] = 1'b0;
  endtask

  // Latency counted from the cycle rd_req is first sampled in IDLE (cycle 0)
  task automatic finish_read(input int i, input logic [7:0] exp, input int start);
    int lat;
    lat = start;
    while (lat < 60) begin
      @(negedge clk);
      if (rd_rdy[i]) break;
      lat++;
    end
    chk($sformatf("lat%0d", i), lat, 2 + (i == 1 ? 10 : 0));
    chk($sformatf("data%0d", i), int'(rd_data[i]), int'(exp));
    repeat (2) begin
      @(negedge clk);
      chk($sformatf("hold_rdy%0d", i), int'(rd_rdy[i]), 1);
      chk($sformatf("hold_data%0d", i), int'(rd_data[i]), int'(exp));
    end
    @(posedge clk); #1;
    rd_req[i] = 1'b0;
    @(negedge clk);
    chk($sformatf("rdy_before_fall%0d", i), int'(rd_rdy[i]), 1);
    @(negedge clk);
    chk($sformatf("rdy_fall%0d", i), int'(rd_rdy[i]), 0);
  endtask

  task automatic read_txn(input int i, input logic [7:0] a, input logic [7:0] exp);
    rd_addr[i] = a;
    rd_req[i]  = 1'b1;
    @(posedge clk); #1;
    wr_en[i] = 1'b0; swap_req[i] = 1'b0;
    finish_read(i, exp, 1);
  endtask

  initial begin
    int  lat;
    bit  seen;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; wr_en[i] = 1'b0; wr_addr[i] = '0; wr_data[i] = '0;
      swap_req[i] = 1'b0; rd_req[i] = 1'b0; rd_addr[i] = '0;
    end

    //        w     wa      wd     s     r     ra      ed     ef    ep
    tbl.push_back('{1'b1, 8'd0,   8'h11, 1'b0, 1'b0, 8'd0,   8'h00, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 8'd4,   8'h44, 1'b0, 1'b0, 8'd0,   8'h00, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 8'd5,   8'hA5, 1'b0, 1'b0, 8'd0,   8'h00, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 8'd7,   8'h77, 1'b0, 1'b0, 8'd0,   8'h00, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 8'd215, 8'hEE, 1'b0, 1'b0, 8'd0,   8'h00, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 8'd220, 8'hFF, 1'b0, 1'b0, 8'd0,   8'h00, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 8'd0,   8'h00, 1'b1, 1'b0, 8'd0,   8'h00, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 8'd0,   8'h00, 1'b0, 1'b1, 8'd0,   8'h11, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 8'd0,   8'h00, 1'b0, 1'b1, 8'd5,   8'hA5, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 8'd0,   8'h00, 1'b0, 1'b1, 8'd4,   8'h44, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 8'd0,   8'h00, 1'b0, 1'b1, 8'd215, 8'hEE, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 8'd0,   8'h00, 1'b0, 1'b1, 8'd216, 8'h00, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 8'd0,   8'h00, 1'b0, 1'b1, 8'd255, 8'h00, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 8'd0,   8'h22, 1'b0, 1'b0, 8'd0,   8'h00, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 8'd7,   8'hC3, 1'b0, 1'b0, 8'd0,   8'h00, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 8'd0,   8'h00, 1'b1, 1'b0, 8'd0,   8'h00, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 8'd0,   8'h00, 1'b0, 1'b1, 8'd7,   8'h77, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 8'd0,   8'h00, 1'b0, 1'b1, 8'd0,   8'h22, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 8'd0,   8'h00, 1'b0, 1'b1, 8'd7,   8'hC3, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 8'd0,   8'h00, 1'b1, 1'b0, 8'd0,   8'h00, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 8'd5,   8'h5A, 1'b1, 1'b1, 8'd0,   8'h11, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 8'd0,   8'h00, 1'b0, 1'b1, 8'd5,   8'h5A, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 8'd0,   8'h00, 1'b0, 1'b1, 8'd0,   8'h22, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 8'd7,   8'h99, 1'b0, 1'b1, 8'd7,   8'hC3, 1'b0, 1'b0});

    repeat (3) cyc();
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_rdy%0d", i),   int'(rd_rdy[i]), 0);
      chk($sformatf("rst_data%0d", i),  int'(rd_data[i]), 0);
      chk($sformatf("rst_front%0d", i), int'(front_bank[i]), 0);
      chk($sformatf("rst_pend%0d", i),  int'(swap_pending[i]), 0);
    end

    // Vector table on the zero-delay instance
    foreach (tbl[k]) begin
      cyc();
      wr_en[0] = tbl[k].w; wr_addr[0] = tbl[k].wa; wr_data[0] = tbl[k].wd;
      swap_req[0] = tbl[k].s;
      if (tbl[k].r) begin
        read_txn(0, tbl[k].ra, tbl[k].ed);
      end else begin
        cyc();
        wr_en[0] = 1'b0; swap_req[0] = 1'b0;
        @(negedge clk);
      end
      chk($sformatf("v%0d_front", k), int'(front_bank[0]), int'(tbl[k].ef));
      chk($sformatf("v%0d_pend", k),  int'(swap_pending[0]), int'(tbl[k].ep));
    end

    // Long-latency read after filling and swapping the back bank
    pulse(1, 1'b1, 8'd0, 8'h9D, 1'b0);
    pulse(1, 1'b1, 8'd3, 8'h3C, 1'b0);
    pulse(1, 1'b0, 8'd0, 8'h00, 1'b1);
    cyc();
    read_txn(1, 8'd0, 8'h9D);
    chk("d_front", int'(front_bank[1]), 1);
    chk("d_pend",  int'(swap_pending[1]), 0);
    pulse(1, 1'b1, 8'd3, 8'hB7, 1'b0);

    // Abort while waiting: no rd_rdy, rd_data untouched
    cyc();
    rd_addr[1] = 8'd3; rd_req[1] = 1'b1;
    repeat (5) cyc();
    rd_req[1] = 1'b0;
    seen = 1'b0;
    repeat (16) begin
      @(negedge clk);
      if (rd_rdy[1]) seen = 1'b1;
    end
    chk("abort_rdy", int'(seen), 0);
    chk("abort_data", int'(rd_data[1]), 8'h9D);

    // Reset during WAIT with rd_req held: fresh full-latency request after
    cyc();
    rd_addr[1] = 8'd3; rd_req[1] = 1'b1;
    repeat (6) cyc();
    rst[1] = 1'b1;
    cyc();
    rst[1] = 1'b0;
    @(negedge clk);
    chk("rstw_rdy",   int'(rd_rdy[1]), 0);
    chk("rstw_front", int'(front_bank[1]), 0);
    chk("rstw_pend",  int'(swap_pending[1]), 0);
    chk("rstw_data",  int'(rd_data[1]), 0);
    finish_read(1, 8'hB7, 1);

    // Back-to-back after reset: channel 0 of bank 0 was never written, so
    // only the latency is meaningful here; use an out-of-range address
    cyc();
    lat = 0;
    read_txn(1, 8'd250, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog so a stuck handshake still ends the run
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1);
  end
endmodule
